// File: rtl/lathe_ctrl_pkg.sv
// Shared state encoding, fault codes and coil decode for the
// spindle star-delta starter.
package lathe_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STAR  = 3'd1,
        S_DEAD  = 3'd2,
        S_RUN   = 3'd3,
        S_STOP  = 3'd4,
        S_FAULT = 3'd5
    } state_e;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_TIMEOUT   = 2'b01;
    localparam logic [1:0] FC_INTERLOCK = 2'b10;

    typedef struct packed {
        logic main;
        logic star;
        logic delta;
    } coils_t;

    function automatic coils_t coils_of(input state_e s);
        coils_t c;
        c = '0;
        unique case (s)
            S_STAR:  c = '{main: 1'b1, star: 1'b1, delta: 1'b0};
            S_DEAD:  c = '{main: 1'b1, star: 1'b0, delta: 1'b0};
            S_RUN:   c = '{main: 1'b1, star: 1'b0, delta: 1'b1};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ton_timer.sv
// Clear/enable up-counter; done flags the preset-1 count and
// the count holds there until cleared.
module ton_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ena_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] preset_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == preset_i - W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !done_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (ena_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/star_delta_starter.sv
// Star-delta contactor sequencer for the lathe spindle motor.
// Define CONTACTOR_FB_EN to supervise aux feedback and latch faults.
module star_delta_starter
    import lathe_ctrl_pkg::*;
#(
    parameter int STAR_TIME  = 150_000_000,
    parameter int DEAD_TIME  = 1_000_000,
    parameter int FB_TIMEOUT = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       cmd_run,
    input  logic       fault_clr,
    input  logic       fb_main,
    input  logic       fb_star,
    input  logic       fb_delta,
    output logic       k_main,
    output logic       k_star,
    output logic       k_delta,
    output logic       run_ack,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state_o
);

    localparam int T_SD  = (STAR_TIME > DEAD_TIME) ? STAR_TIME : DEAD_TIME;
    localparam int T_MAX = (T_SD > FB_TIMEOUT) ? T_SD : FB_TIMEOUT;
    localparam int CNT_W = $clog2(T_MAX) + 1;

    state_e           state_q, state_d;
    logic             cmd_q;
    logic [1:0]       code_q, code_d;
    coils_t           coil_q, coil_d;
    logic [CNT_W-1:0] preset;
    logic             tmr_clr, tmr_done;
    logic             interlock, fb_timeout;

    assign coil_q = coils_of(state_q);
    assign coil_d = coils_of(state_d);

    always_comb begin
        preset = CNT_W'(STAR_TIME);
        if (state_q == S_DEAD || state_q == S_STOP) begin
            preset = CNT_W'(DEAD_TIME);
        end
    end

    assign tmr_clr = (state_d != state_q);

    ton_timer #(.W(CNT_W)) u_state_tmr (
        .clk_i    (clk),
        .rst_i    (reset),
        .ena_i    (ena),
        .clr_i    (tmr_clr),
        .inc_i    (1'b1),
        .preset_i (preset),
        .done_o   (tmr_done)
    );

`ifdef CONTACTOR_FB_EN
    logic mism, mis_clr, mis_done, in_fault;

    assign in_fault  = (state_q == S_FAULT);
    assign mism      = (fb_main  != coil_q.main)
                     | (fb_star  != coil_q.star)
                     | (fb_delta != coil_q.delta);
    assign mis_clr   = !mism || (coil_d != coil_q) || in_fault;
    assign interlock = fb_star && fb_delta;
    assign fb_timeout = mism && mis_done;

    ton_timer #(.W(CNT_W)) u_mis_tmr (
        .clk_i    (clk),
        .rst_i    (reset),
        .ena_i    (ena),
        .clr_i    (mis_clr),
        .inc_i    (1'b1),
        .preset_i (CNT_W'(FB_TIMEOUT)),
        .done_o   (mis_done)
    );
`else
    logic unused_fb;
    assign unused_fb  = ^{fb_main, fb_star, fb_delta};
    assign interlock  = 1'b0;
    assign fb_timeout = 1'b0;
`endif

    // Supervision outranks sequencing; FAULT itself is never re-checked.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (state_q != S_FAULT && interlock) begin
            state_d = S_FAULT;
            code_d  = FC_INTERLOCK;
        end else if (state_q != S_FAULT && fb_timeout) begin
            state_d = S_FAULT;
            code_d  = FC_TIMEOUT;
        end else begin
            unique case (state_q)
                S_IDLE: if (cmd_q) state_d = S_STAR;
                S_STAR: begin
                    if (!cmd_q)        state_d = S_STOP;
                    else if (tmr_done) state_d = S_DEAD;
                end
                S_DEAD: begin
                    if (!cmd_q)        state_d = S_STOP;
                    else if (tmr_done) state_d = S_RUN;
                end
                S_RUN:  if (!cmd_q)    state_d = S_STOP;
                S_STOP: if (tmr_done)  state_d = S_IDLE;
                S_FAULT: begin
                    if (fault_clr && !cmd_q) begin
                        state_d = S_IDLE;
                        code_d  = FC_NONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= 1'b0;
            code_q  <= FC_NONE;
        end else if (ena) begin
            state_q <= state_d;
            cmd_q   <= cmd_run;
            code_q  <= code_d;
        end
    end

    assign k_main     = coil_q.main;
    assign k_star     = coil_q.star;
    assign k_delta    = coil_q.delta;
    assign run_ack    = (state_q == S_RUN);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = code_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_star_delta_starter.sv
// Randomized bench for star_delta_starter against a countdown model.
// Fault scenarios run only when CONTACTOR_FB_EN is defined.
module tb_star_delta_starter;

    localparam int ST = 8;
    localparam int DT = 3;
    localparam int FT = 5;

    logic clk = 1'b0;
    logic reset, ena, cmd_run, fault_clr;
    logic fb_main, fb_star, fb_delta;
    logic k_main, k_star, k_delta, run_ack, fault;
    logic [1:0] fault_code;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [2:0] lag, frc_en, frc_v;

    int m_st, m_left, m_mis, m_ns, m_run;
    logic m_cmd, m_mm, m_ilk, m_tmo;
    logic [1:0] m_code;
    logic [2:0] m_kc;

    star_delta_starter #(
        .STAR_TIME  (ST),
        .DEAD_TIME  (DT),
        .FB_TIMEOUT (FT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .cmd_run    (cmd_run),
        .fault_clr  (fault_clr),
        .fb_main    (fb_main),
        .fb_star    (fb_star),
        .fb_delta   (fb_delta),
        .k_main     (k_main),
        .k_star     (k_star),
        .k_delta    (k_delta),
        .run_ack    (run_ack),
        .fault      (fault),
        .fault_code (fault_code),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // {main, star, delta} per numbered state
    function automatic logic [2:0] mcoils(input int s);
        if (s == 1) return 3'b110;
        if (s == 2) return 3'b100;
        if (s == 3) return 3'b101;
        return 3'b000;
    endfunction

    task automatic model_step();
        m_kc  = mcoils(m_st);
        m_mm  = ({fb_main, fb_star, fb_delta} != m_kc);
        m_run = m_mm ? m_mis + 1 : 0;
`ifdef CONTACTOR_FB_EN
        m_ilk = fb_star && fb_delta;
        m_tmo = m_mm && (m_run >= FT);
`else
        m_ilk = 1'b0;
        m_tmo = 1'b0;
`endif
        m_ns = m_st;
        if (m_st != 5 && m_ilk) begin
            m_ns = 5; m_code = 2'd2;
        end else if (m_st != 5 && m_tmo) begin
            m_ns = 5; m_code = 2'd1;
        end else begin
            case (m_st)
                0: if (m_cmd) begin m_ns = 1; m_left = ST; end
                1, 2: begin
                    if (!m_cmd) begin
                        m_ns = 4; m_left = DT;
                    end else if (m_left == 1) begin
                        m_ns = m_st + 1; m_left = DT;
                    end else begin
                        m_left--;
                    end
                end
                3: if (!m_cmd) begin m_ns = 4; m_left = DT; end
                4: if (m_left == 1) m_ns = 0; else m_left--;
                5: if (fault_clr && !m_cmd) begin m_ns = 0; m_code = 2'd0; end
                default: m_ns = 0;
            endcase
        end
        if (!m_mm || mcoils(m_ns) != m_kc || m_st == 5) m_mis = 0;
        else m_mis = m_run;
        m_st  = m_ns;
        m_cmd = cmd_run;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_st = 0; m_left = 0; m_mis = 0;
                m_cmd = 1'b0; m_code = 2'd0;
            end else if (ena) begin
                model_step();
            end
        end
    end

    initial begin
        logic [9:0] act, exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp = {mcoils(m_st), m_st == 3, m_st == 5, m_code, 3'(m_st)};
                act = {k_main, k_star, k_delta, run_ack, fault,
                       fault_code, state_o};
                n_cmp++;
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL cycle t=%0t got %b want %b",
                             $time, act, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    // Plant: aux contacts follow the coils one cycle late unless forced.
    task automatic tick();
        {fb_main, fb_star, fb_delta} = (frc_en & frc_v) | (~frc_en & lag);
        @(negedge clk);
        lag = {k_main, k_star, k_delta};
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int st[0:15];
        int r[0:4];
        int n;
        reset = 1'b1; ena = 1'b1; cmd_run = 1'b0; fault_clr = 1'b0;
        lag = '0; frc_en = '0; frc_v = '0;
        {fb_main, fb_star, fb_delta} = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_state", int'(state_o), 0);
        chk("reset_coils", int'({k_main, k_star, k_delta}), 0);
        ticks(2);

        // normal start
        cmd_run = 1'b1;
        for (int e = 0; e <= 13; e++) begin
            tick();
            st[e] = int'(state_o);
        end
        chk("t1_e0_idle", st[0], 0);
        chk("t1_e1_star", st[1], 1);
        chk("t1_e8_star", st[8], 1);
        chk("t1_e9_dead", st[9], 2);
        chk("t1_e11_dead", st[11], 2);
        chk("t1_e12_run", st[12], 3);
        chk("t1_run_ack", int'(run_ack), 1);

        // stop in STAR, early re-request ignored
        cmd_run = 1'b0;
        ticks(8);
        cmd_run = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            tick();
            st[e] = int'(state_o);
            if (e == 3) cmd_run = 1'b0;
            if (e == 5) cmd_run = 1'b1;
        end
        chk("t2_e4_star", st[4], 1);
        chk("t2_e5_stop", st[5], 4);
        chk("t2_e7_stop", st[7], 4);
        chk("t2_e8_idle", st[8], 0);
        chk("t2_e9_star", st[9], 1);
        ticks(16);
        chk("t2_run", int'(state_o), 3);

`ifdef CONTACTOR_FB_EN
        // main feedback lost in RUN
        frc_en = 3'b100; frc_v = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            r[i] = int'(fault);
        end
        chk("t3_no_fault_4", r[3], 0);
        chk("t3_fault_5", r[4], 1);
        chk("t3_code", int'(fault_code), 1);
        chk("t3_coils_off", int'({k_main, k_star, k_delta}), 0);
        fault_clr = 1'b1;
        ticks(3);
        chk("t3_hold_cmd", int'(fault), 1);
        frc_en = '0;
        cmd_run = 1'b0;
        ticks(2);
        chk("t3_clr_state", int'(state_o), 0);
        chk("t3_clr_fault", int'(fault), 0);
        chk("t3_clr_code", int'(fault_code), 0);
        fault_clr = 1'b0;

        // interlock coinciding with timeout
        cmd_run = 1'b1;
        ticks(20);
        chk("t4_run", int'(state_o), 3);
        frc_en = 3'b100; frc_v = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            r[i] = int'(fault);
            if (i == 3) begin frc_en = 3'b110; frc_v = 3'b010; end
        end
        chk("t4_no_fault_4", r[3], 0);
        chk("t4_fault", int'(fault), 1);
        chk("t4_code", int'(fault_code), 2);
        frc_en = '0;
        cmd_run = 1'b0;
        fault_clr = 1'b1;
        ticks(4);
        chk("t4_clr", int'(state_o), 0);
        fault_clr = 1'b0;
        cmd_run = 1'b1;
        ticks(20);
`endif

        // async reset mid-RUN
        chk("t5_run", int'(state_o), 3);
        #2 reset = 1'b1;
        #1;
        chk("t5_coils", int'({k_main, k_star, k_delta}), 0);
        chk("t5_ack", int'(run_ack), 0);
        chk("t5_state", int'(state_o), 0);
        cmd_run = 1'b0;
        tick();
        reset = 1'b0;
        ticks(4);

        // clock-enable freeze in STAR
        cmd_run = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (state_o == 3'd1) n++;
            if (i == 3) ena = 1'b0;
            if (i == 7) ena = 1'b1;
        end
        chk("t6_star_len", n, 12);

        // random soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) cmd_run = !cmd_run;
            ena = ($urandom_range(0, 9) != 0);
            fault_clr = ($urandom_range(0, 5) == 0);
`ifdef CONTACTOR_FB_EN
            if ($urandom_range(0, 49) == 0) begin
                n = $urandom_range(0, 2);
                frc_en[n] = !frc_en[n];
                frc_v = 3'($urandom_range(0, 7));
            end
`else
            frc_en = 3'b111;
            frc_v = 3'($urandom_range(0, 7));
`endif
            tick();
        end
`ifndef CONTACTOR_FB_EN
        chk("t6_no_fault", int'(fault), 0);
        chk("t6_no_code", int'(fault_code), 0);
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
